// File: rtl/motoro3_pkg.sv
// Shared motoro3 types and constants: drive state, step geometry and step-length clamp.
package motoro3_pkg;

    localparam int STEP_NUM = 12;
    localparam int CNT_W    = 25;

    localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(4);

    localparam logic [3:0] STEP_LAST   = 4'd11;
    localparam logic [3:0] STEP_B_PULL = 4'd6;
    localparam logic [3:0] STEP_C_PULL = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } m3State_t;

    // Clamp keeps First2/First1/Last2/Last1 on distinct counter values.
    function automatic logic [CNT_W-1:0] clampLen(input logic [CNT_W-1:0] len);
        return (len < MIN_LEN) ? MIN_LEN : len;
    endfunction

endpackage

// File: rtl/motoro3_step_counter.sv
// Per-step down-counter with clamped length reload and first/last-cycle strobe decode.
module motoro3_step_counter
    import motoro3_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             active,
    input  logic             load,
    input  logic             clear,
    input  logic [CNT_W-1:0] stepLen,
    output logic [CNT_W-1:0] m3cnt,
    output logic             cntFirst2,
    output logic             cntFirst1,
    output logic             cntLast2,
    output logic             cntLast1
);

    logic [CNT_W-1:0] lenReg;
    logic [CNT_W-1:0] lenNext;

    assign lenNext = clampLen(stepLen);

    always_ff @(posedge clk) begin
        if (rst) begin
            m3cnt  <= '0;
            lenReg <= MIN_LEN;
        end else if (clear) begin
            m3cnt <= '0;
        end else if (load || (active && (m3cnt == '0))) begin
            lenReg <= lenNext;
            m3cnt  <= lenNext - CNT_W'(1);
        end else if (active) begin
            m3cnt <= m3cnt - CNT_W'(1);
        end
    end

    always_comb begin
        cntFirst2 = active && (m3cnt == lenReg - CNT_W'(1));
        cntFirst1 = active && (m3cnt == lenReg - CNT_W'(2));
        cntLast2  = active && (m3cnt == CNT_W'(1));
        cntLast1  = active && (m3cnt == '0);
    end

endmodule

// File: rtl/motoro3_step_sequencer.sv
// Commutation step sequencer: 12-step rotation timing plus start / graceful-stop / abort control.
module motoro3_step_sequencer
    import motoro3_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] m3r_stepLen,
    input  logic             startReq,
    input  logic             stopReq,
    input  logic             abortReq,
    output logic [3:0]       sgStep,
    output logic [CNT_W-1:0] m3cnt,
    output logic             m3cntFirst2,
    output logic             m3cntFirst1,
    output logic             m3cntLast2,
    output logic             m3cntLast1,
    output logic             pwmActive1,
    output logic             pwmLastStep1,
    output logic [15:0]      rotCnt,
    output logic             stopDone
);

    m3State_t state, nextState;
    logic     stopPending;
    logic     active;
    logic     startLoad;
    logic     toIdle;
    logic     lastStep;

    assign active    = (state != IDLE);
    assign startLoad = (state == IDLE) && (nextState == RUN);
    assign toIdle    = active && (nextState == IDLE);
    assign lastStep  = (sgStep == STEP_LAST);

    motoro3_step_counter uCounter (
        .clk       (clk),
        .rst       (rst),
        .active    (active),
        .load      (startLoad),
        .clear     (toIdle),
        .stepLen   (m3r_stepLen),
        .m3cnt     (m3cnt),
        .cntFirst2 (m3cntFirst2),
        .cntFirst1 (m3cntFirst1),
        .cntLast2  (m3cntLast2),
        .cntLast1  (m3cntLast1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // A stop seen during step 11 stays pending in RUN until that rotation wraps.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (startReq && !stopReq && !abortReq) nextState = RUN;
            end
            RUN: begin
                if (abortReq) nextState = IDLE;
                else if (stopReq && !lastStep) nextState = STOPPING;
                else if (stopPending && m3cntLast1 && lastStep) nextState = STOPPING;
            end
            STOPPING: begin
                if (abortReq) nextState = IDLE;
                else if (m3cntLast1 && lastStep) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        pwmActive1   = active;
        pwmLastStep1 = (state == STOPPING) && lastStep;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sgStep      <= '0;
            rotCnt      <= '0;
            stopDone    <= 1'b0;
            stopPending <= 1'b0;
        end else begin
            stopDone    <= toIdle;
            stopPending <= (nextState == RUN) &&
                           (stopPending || ((state == RUN) && stopReq && lastStep));
            if (toIdle || startLoad) begin
                sgStep <= '0;
            end else if (m3cntLast1) begin
                sgStep <= (sgStep == 4'(STEP_NUM - 1)) ? '0 : sgStep + 4'd1;
            end
            if (m3cntLast1 && lastStep && !abortReq) begin
                rotCnt <= rotCnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Directed self-checking bench for motoro3_step_sequencer.
`timescale 1ns/1ps
module tb_motoro3_step_sequencer;
    import motoro3_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] m3r_stepLen;
    logic             startReq, stopReq, abortReq;
    logic [3:0]       sgStep;
    logic [CNT_W-1:0] m3cnt;
    logic             m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1;
    logic             pwmActive1, pwmLastStep1;
    logic [15:0]      rotCnt;
    logic             stopDone;

    int errors = 0;
    int checks = 0;

    motoro3_step_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .m3r_stepLen  (m3r_stepLen),
        .startReq     (startReq),
        .stopReq      (stopReq),
        .abortReq     (abortReq),
        .sgStep       (sgStep),
        .m3cnt        (m3cnt),
        .m3cntFirst2  (m3cntFirst2),
        .m3cntFirst1  (m3cntFirst1),
        .m3cntLast2   (m3cntLast2),
        .m3cntLast1   (m3cntLast1),
        .pwmActive1   (pwmActive1),
        .pwmLastStep1 (pwmLastStep1),
        .rotCnt       (rotCnt),
        .stopDone     (stopDone)
    );

    always #50 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] strobes();
        return {m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1};
    endfunction

    // Advance until the first cycle of step s; a timeout counts as a failure.
    task automatic waitStep(input logic [3:0] s);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(sgStep == s && m3cntFirst2) && n < 200);
        chk("waitStep_timeout", 32'(n < 200), 32'd1);
    endtask

    task automatic measureStep(output int len);
        logic [3:0] s0 = sgStep;
        len = 0;
        do begin
            tick();
            len++;
        end while (sgStep == s0 && len < 100);
    endtask

    initial begin
        int len;
        rst = 1'b1; startReq = 1'b0; stopReq = 1'b0; abortReq = 1'b0;
        m3r_stepLen = CNT_W'(10);
        tick(); tick();
        chk("rst_sgStep", 32'(sgStep), 0);
        chk("rst_m3cnt", 32'(m3cnt), 0);
        chk("rst_strobes", 32'(strobes()), 0);
        chk("rst_active", 32'(pwmActive1), 0);
        chk("rst_rotCnt", 32'(rotCnt), 0);
        chk("rst_stopDone", 32'(stopDone), 0);
        rst = 1'b0;

        // Start with length 10
        startReq = 1'b1;
        tick();
        startReq = 1'b0;
        chk("start_sgStep", 32'(sgStep), 0);
        chk("start_m3cnt", 32'(m3cnt), 9);
        chk("start_first2", 32'(strobes()), 32'b1000);
        chk("start_active", 32'(pwmActive1), 1);
        tick();
        chk("c1_m3cnt", 32'(m3cnt), 8);
        chk("c1_first1", 32'(strobes()), 32'b0100);
        for (int k = 2; k < 9; k++) tick();
        chk("c8_m3cnt", 32'(m3cnt), 1);
        chk("c8_last2", 32'(strobes()), 32'b0010);
        tick();
        chk("c9_m3cnt", 32'(m3cnt), 0);
        chk("c9_last1", 32'(strobes()), 32'b0001);
        chk("c9_sgStep", 32'(sgStep), 0);
        tick();
        chk("s1_sgStep", 32'(sgStep), 1);
        chk("s1_m3cnt", 32'(m3cnt), 9);

        // Length change mid-step applies only to the next step
        m3r_stepLen = CNT_W'(20);
        measureStep(len);
        chk("lenchg_cur", 32'(len), 10);
        chk("s2_m3cnt", 32'(m3cnt), 19);
        m3r_stepLen = CNT_W'(2);
        measureStep(len);
        chk("lenchg_next", 32'(len), 20);

        // Clamped step: 3,2,1,0 with one strobe per cycle
        chk("clamp_sgStep", 32'(sgStep), 3);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] expS;
            expS = 4'b1000 >> i;
            chk("clamp_m3cnt", 32'(m3cnt), 32'(3 - i));
            chk("clamp_strobes", 32'(strobes()), 32'(expS));
            tick();
        end
        chk("clamp_next", 32'(sgStep), 4);
        chk("clamp_reload", 32'(m3cnt), 3);

        // Abort together with stop mid-step 7
        waitStep(4'd7);
        tick();
        abortReq = 1'b1; stopReq = 1'b1;
        tick();
        abortReq = 1'b0; stopReq = 1'b0;
        chk("abort_active", 32'(pwmActive1), 0);
        chk("abort_sgStep", 32'(sgStep), 0);
        chk("abort_m3cnt", 32'(m3cnt), 0);
        chk("abort_strobes", 32'(strobes()), 0);
        chk("abort_stopDone", 32'(stopDone), 1);
        chk("abort_rotCnt", 32'(rotCnt), 0);
        tick();
        chk("abort_pulse", 32'(stopDone), 0);
        startReq = 1'b1; stopReq = 1'b1;
        tick();
        startReq = 1'b0; stopReq = 1'b0;
        chk("startstop_idle", 32'(pwmActive1), 0);
        chk("startstop_m3cnt", 32'(m3cnt), 0);

        // Graceful stop requested in step 4
        m3r_stepLen = CNT_W'(4);
        startReq = 1'b1;
        tick();
        startReq = 1'b0;
        waitStep(4'd4);
        stopReq = 1'b1;
        tick();
        stopReq = 1'b0;
        chk("stop_active", 32'(pwmActive1), 1);
        waitStep(4'd11);
        for (int i = 0; i < 4; i++) begin
            chk("stop_lastStep", 32'(pwmLastStep1), 1);
            chk("stop_m3cnt", 32'(m3cnt), 32'(3 - i));
            chk("stop_rotCnt_pre", 32'(rotCnt), 0);
            tick();
        end
        chk("stop_idle", 32'(pwmActive1), 0);
        chk("stop_done", 32'(stopDone), 1);
        chk("stop_rotCnt", 32'(rotCnt), 1);
        chk("stop_sgStep", 32'(sgStep), 0);
        chk("stop_m3cnt0", 32'(m3cnt), 0);
        chk("stop_lastStep0", 32'(pwmLastStep1), 0);
        tick();
        chk("stop_pulse", 32'(stopDone), 0);

        // Reset while running
        startReq = 1'b1;
        tick();
        startReq = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_active", 32'(pwmActive1), 0);
        chk("midrst_m3cnt", 32'(m3cnt), 0);
        chk("midrst_rotCnt", 32'(rotCnt), 0);
        chk("midrst_stopDone", 32'(stopDone), 0);

        // Stop in step 11 is deferred by one full rotation
        startReq = 1'b1;
        tick();
        startReq = 1'b0;
        waitStep(4'd11);
        chk("defer_run_lastStep", 32'(pwmLastStep1), 0);
        stopReq = 1'b1;
        tick();
        stopReq = 1'b0;
        chk("defer_still_run", 32'(pwmLastStep1), 0);
        waitStep(4'd0);
        chk("defer_rot1_rotCnt", 32'(rotCnt), 1);
        chk("defer_rot1_active", 32'(pwmActive1), 1);
        waitStep(4'd11);
        chk("defer_lastStep", 32'(pwmLastStep1), 1);
        for (int i = 0; i < 4; i++) tick();
        chk("defer_idle", 32'(pwmActive1), 0);
        chk("defer_done", 32'(stopDone), 1);
        chk("defer_rotCnt", 32'(rotCnt), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
